// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Transmit side of the systolic array row interface. A command supplies
//   a vector count. That many N-element vectors are then taken from the
//   unified buffer over a valid/ready stream. Element r of each vector is
//   presented on row r, r cycles later than row 0, which forms the diagonal
//   wavefront the PE mesh expects. Once the last vector has been taken, the
//   skew pipeline is flushed and a one-cycle done pulse is produced.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   cmd_valid    command request
//   cmd_ready    command accept, high only in IDLE
//   cmd_len      vector count, sampled on the command handshake
//   vec_data     input vector, element r feeds row r
//   vec_valid    input vector present
//   vec_ready    vector accept, high only in LOAD
//   sys_data_in  per-row data to the array (zero whenever its strobe is low)
//   sys_start    per-row valid strobe to the array
//   busy         high whenever the FSM is not in IDLE
//   done         one-cycle completion pulse
module systolic_feeder #(
  parameter int N          = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic [DATA_WIDTH-1:0] vec_data [N],
  input  logic                  vec_valid,
  output logic                  vec_ready,
  output logic [DATA_WIDTH-1:0] sys_data_in [N],
  output logic                  sys_start [N],
  output logic                  busy,
  output logic                  done
);

  localparam int DRAIN_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t               state_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [DRAIN_W-1:0]   drain_q;
  logic                 done_q;

  logic cmd_fire;
  logic vec_fire;

  assign cmd_ready = (state_q == S_IDLE);
  assign vec_ready = (state_q == S_LOAD);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign vec_fire = vec_valid && vec_ready;

  // Control FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            rem_q <= cmd_len;
            if (cmd_len != '0) begin
              state_q <= S_LOAD;
            end else begin
              // An empty command completes immediately.
              done_q <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (vec_fire) begin
            rem_q <= rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
              state_q <= S_DRAIN;
              drain_q <= DRAIN_INIT;
            end
          end
        end
        S_DRAIN: begin
          // The last element reaches row N-1 in the final DRAIN cycle.
          if (drain_q == '0) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Skew pipeline: row r has r+1 stages; the last stage drives the row.
  // Stage 0 zeroes data on an idle cycle, and later stages copy unchanged,
  // so every stage holds zero data whenever its valid is low.
  for (genvar r = 0; r < N; r++) begin : g_row
    logic                  vld_q [0:r];
    logic [DATA_WIDTH-1:0] dat_q [0:r];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int s = 0; s <= r; s++) begin
          vld_q[s] <= 1'b0;
          dat_q[s] <= '0;
        end
      end else begin
        vld_q[0] <= vec_fire;
        dat_q[0] <= vec_fire ? vec_data[r] : '0;
        for (int s = 1; s <= r; s++) begin
          vld_q[s] <= vld_q[s-1];
          dat_q[s] <= dat_q[s-1];
        end
      end
    end

    assign sys_start[r]   = vld_q[r];
    assign sys_data_in[r] = dat_q[r];
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 16;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len;
  logic [DW-1:0] vec_data [N];
  logic          vec_valid;
  logic          vec_ready;
  logic [DW-1:0] sys_data_in [N];
  logic          sys_start [N];
  logic          busy;
  logic          done;

  int n_vec;
  int n_err;

  systolic_feeder #(.N(N), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .vec_data    (vec_data),
    .vec_valid   (vec_valid),
    .vec_ready   (vec_ready),
    .sys_data_in (sys_data_in),
    .sys_start   (sys_start),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; outputs then show the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int base);
    for (int r = 0; r < N; r++) vec_data[r] = DW'(base + r);
  endtask

  task automatic issue_cmd(input int len);
    cmd_valid = 1'b1;
    cmd_len   = LW'(len);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    n_vec++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    n_vec++;
    if (vec_ready !== 1'b0) begin n_err++; $display("FAIL reset_vec_ready got=%b exp=0", vec_ready); end
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
    for (int r = 0; r < N; r++) begin
      n_vec++;
      if (sys_start[r] !== 1'b0 || sys_data_in[r] !== '0) begin
        n_err++;
        $display("FAIL reset_row%0d got start=%b data=%0h exp start=0 data=0", r, sys_start[r], sys_data_in[r]);
      end
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  // Single vector {10,11,12,13}; c is cycles relative to the accept cycle.
  task automatic test_single();
    issue_cmd(1);
    for (int c = 0; c <= 7; c++) begin
      for (int r = 0; r < N; r++) begin
        n_vec++;
        if (sys_start[r] !== (c == 1 + r) || sys_data_in[r] !== ((c == 1 + r) ? DW'(10 + r) : '0)) begin
          n_err++;
          $display("FAIL single c=%0d row=%0d got start=%b data=%0d exp start=%b data=%0d", c, r,
                   sys_start[r], sys_data_in[r], (c == 1 + r), (c == 1 + r) ? 10 + r : 0);
        end
      end
      n_vec++;
      if (done !== (c == 5) || busy !== (c <= 4) || vec_ready !== (c == 0)) begin
        n_err++;
        $display("FAIL single_ctl c=%0d got done=%b busy=%b vrdy=%b exp done=%b busy=%b vrdy=%b", c,
                 done, busy, vec_ready, (c == 5), (c <= 4), (c == 0));
      end
      vec_valid = (c == 0);
      set_vec(10);
      tick();
    end
    vec_valid = 1'b0;
  endtask

  // Four vectors v_k[r] = 16k+r accepted back-to-back at c=0..3.
  task automatic test_four();
    issue_cmd(4);
    for (int c = 0; c <= 10; c++) begin
      for (int r = 0; r < N; r++) begin
        int k;
        logic ex_s;
        k = c - 1 - r;
        ex_s = (k >= 0 && k < 4);
        n_vec++;
        if (sys_start[r] !== ex_s || sys_data_in[r] !== (ex_s ? DW'(16 * k + r) : '0)) begin
          n_err++;
          $display("FAIL four c=%0d row=%0d got start=%b data=%0d exp start=%b data=%0d", c, r,
                   sys_start[r], sys_data_in[r], ex_s, ex_s ? 16 * k + r : 0);
        end
      end
      n_vec++;
      if (done !== (c == 8)) begin
        n_err++;
        $display("FAIL four_done c=%0d got=%b exp=%b", c, done, (c == 8));
      end
      vec_valid = (c < 4);
      set_vec(16 * c);
      tick();
    end
    vec_valid = 1'b0;
  endtask

  // Three vectors accepted at c=0,3,4 with a two-cycle gap; v_k[r]=100+16k+r.
  task automatic test_bubble();
    int acc [3] = '{0, 3, 4};
    issue_cmd(3);
    for (int c = 0; c <= 11; c++) begin
      for (int r = 0; r < N; r++) begin
        int k;
        k = -1;
        for (int j = 0; j < 3; j++) if (c - 1 - r == acc[j]) k = j;
        n_vec++;
        if (sys_start[r] !== (k >= 0) || sys_data_in[r] !== ((k >= 0) ? DW'(100 + 16 * k + r) : '0)) begin
          n_err++;
          $display("FAIL bubble c=%0d row=%0d got start=%b data=%0d exp start=%b data=%0d", c, r,
                   sys_start[r], sys_data_in[r], (k >= 0), (k >= 0) ? 100 + 16 * k + r : 0);
        end
      end
      n_vec++;
      if (done !== (c == 9) || vec_ready !== (c <= 4)) begin
        n_err++;
        $display("FAIL bubble_ctl c=%0d got done=%b vrdy=%b exp done=%b vrdy=%b", c, done, vec_ready,
                 (c == 9), (c <= 4));
      end
      vec_valid = (c == 0 || c == 3 || c == 4);
      set_vec(c == 0 ? 100 : (c == 3 ? 116 : 132));
      tick();
    end
    vec_valid = 1'b0;
  endtask

  task automatic test_zero_len();
    cmd_valid = 1'b1;
    cmd_len   = '0;
    n_vec++;
    if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy_hs got=%b exp=0", busy); end
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      logic any_s;
      any_s = 1'b0;
      for (int r = 0; r < N; r++) any_s |= sys_start[r];
      n_vec++;
      if (done !== (c == 1) || busy !== 1'b0 || vec_ready !== 1'b0 || any_s !== 1'b0) begin
        n_err++;
        $display("FAIL zero c=%0d got done=%b busy=%b vrdy=%b start=%b exp done=%b busy=0 vrdy=0 start=0",
                 c, done, busy, vec_ready, any_s, (c == 1));
      end
      tick();
    end
  endtask

  task automatic test_midreset();
    issue_cmd(5);
    vec_valid = 1'b1;
    set_vec(200);
    tick();
    set_vec(216);
    tick();
    vec_valid = 1'b0;
    // Rows 0 and 1 are active now; drop reset between edges.
    #2;
    rst = 1'b0;
    #1;
    for (int r = 0; r < N; r++) begin
      n_vec++;
      if (sys_start[r] !== 1'b0 || sys_data_in[r] !== '0) begin
        n_err++;
        $display("FAIL midrst_row%0d got start=%b data=%0h exp start=0 data=0", r, sys_start[r], sys_data_in[r]);
      end
    end
    n_vec++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || vec_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midrst_ctl got busy=%b crdy=%b vrdy=%b exp busy=0 crdy=1 vrdy=0", busy, cmd_ready, vec_ready);
    end
    tick();
    #2;
    rst = 1'b1;
    tick();
    for (int c = 0; c < 8; c++) begin
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_after c=%0d got done=%b busy=%b exp done=0 busy=0", c, done, busy);
      end
      tick();
    end
    test_single();
  endtask

  // cmd_len=1 then cmd_len=2 with cmd_valid and vec_valid held high throughout.
  // vec_data in cycle c is 0x100+16c+r; accepts expected at c=0,6,7.
  task automatic test_back_to_back();
    issue_cmd(1);
    cmd_valid = 1'b1;
    cmd_len   = LW'(2);
    vec_valid = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      for (int r = 0; r < N; r++) begin
        int a;
        logic ex_s;
        a = c - 1 - r;
        ex_s = (a == 0 || a == 6 || a == 7);
        n_vec++;
        if (sys_start[r] !== ex_s || sys_data_in[r] !== (ex_s ? DW'(256 + 16 * a + r) : '0)) begin
          n_err++;
          $display("FAIL b2b c=%0d row=%0d got start=%b data=%0h exp start=%b data=%0h", c, r,
                   sys_start[r], sys_data_in[r], ex_s, ex_s ? 256 + 16 * a + r : 0);
        end
      end
      n_vec++;
      if (done !== (c == 5 || c == 12) || cmd_ready !== (c == 5 || c >= 12) || busy !== !(c == 5 || c >= 12)) begin
        n_err++;
        $display("FAIL b2b_ctl c=%0d got done=%b crdy=%b busy=%b exp done=%b crdy=%b busy=%b", c, done,
                 cmd_ready, busy, (c == 5 || c == 12), (c == 5 || c >= 12), !(c == 5 || c >= 12));
      end
      if (c == 6) cmd_valid = 1'b0;
      if (c == 8) vec_valid = 1'b0;
      set_vec(256 + 16 * c);
      tick();
    end
    cmd_valid = 1'b0;
    vec_valid = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    cmd_valid = 1'b0;
    cmd_len   = '0;
    vec_valid = 1'b0;
    set_vec(0);
    test_reset();
    test_single();
    test_four();
    test_bubble();
    test_zero_len();
    test_midreset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the systolic array's row input interface. Drives the array's per-row data and per-row start strobes.
- Accepts a command giving a vector count, then accepts that many N-element input vectors over a valid/ready stream from the unified buffer.
- Emits element r of each vector on row r, delayed r cycles relative to row 0, producing the diagonal wavefront the PE mesh requires.
- After the last vector it flushes the skew pipeline and pulses done.

Parameters:
N, 16, array dimension (rows driven, elements per vector)
DATA_WIDTH, 32, element width
LEN_WIDTH, 16, width of vector-count field

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
cmd_valid  input  1  command request
cmd_ready  output  1  command accept; high only in IDLE
cmd_len  input  LEN_WIDTH  number of vectors to stream, sampled on cmd handshake
vec_data  input  [N] x DATA_WIDTH  input vector (unpacked array, element r for row r)
vec_valid  input  1  vector present
vec_ready  output  1  vector accept; high only in LOAD
sys_data_in  output  [N] x DATA_WIDTH  per-row data to array
sys_start  output  [N] x 1  per-row valid strobe to array
busy  output  1  state != IDLE
done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. Assertion immediately clears all state; the clock is not required.
- Reset values:
  - state IDLE; cmd_ready=1; vec_ready=0; busy=0; done=0.
  - All sys_start=0, all sys_data_in=0, all skew registers zero; remaining-vector and drain counters zero.
- Reset mid-operation: in-flight vectors are dropped and no done pulse is produced. The block is back in IDLE on the first edge after release.
- State machine (IDLE, LOAD, DRAIN):
  - IDLE: on cmd_valid && cmd_ready, latch cmd_len into the remaining counter.
    - cmd_len != 0: go to LOAD.
    - cmd_len == 0: stay IDLE and pulse done in the next cycle. No sys_start is asserted.
  - LOAD: vec_ready=1. Each vec_valid && vec_ready decrements the remaining counter. The accept that takes it to zero moves the FSM to DRAIN and loads the drain counter with N-1.
  - DRAIN: vec_ready=0. Decrement the drain counter each cycle. When it is 0, go to IDLE and register done=1 for the following cycle.
- Skew pipeline:
  - Row r has r+1 register stages, each carrying a {valid, data} pair. Stage 0 of every row loads {vec_valid && vec_ready, vec_data[r]}.
  - The outputs sys_start[r] and sys_data_in[r] are the final stage of row r, so they are registered outputs.
- Latency: a vector accepted in cycle t appears as sys_start[r]=1 with sys_data_in[r]=vec_data[r] in cycle t+1+r, for every r.
- Stalls: a LOAD cycle with vec_valid=0 inserts a bubble. That bubble appears in every row with the same skew, so diagonal alignment is preserved.
- Idle data: when a stage's valid is 0 its data is forced to zero, so sys_data_in[r]=0 whenever sys_start[r]=0.
- Completion timing: with the last accept in cycle t, row N-1 presents the last element in cycle t+N.
  - done=1 in cycle t+N+1, in IDLE.
  - cmd_ready is also 1 in that cycle. A new command accepted then does not disturb the done pulse.
- busy is 1 from the cycle after the command handshake through the last DRAIN cycle, and 0 in the done cycle.
- Back-to-back commands: a new command can be accepted in the done cycle. Its first vector is accepted no earlier than the following cycle, so the wavefronts of the two commands do not overlap.
- Ignored inputs: vec_valid outside LOAD, and cmd_valid outside IDLE, are ignored with no side effects.
- Width rules:
  - The remaining counter is LEN_WIDTH bits and cmd_len up to 2^LEN_WIDTH-1 is supported.
  - The drain counter is $clog2(N) bits, minimum 1. N=1 is legal: no DRAIN delay, done in cycle t+2.

Test Plan:
1. Single vector, N=4:
   - Stimulus: cmd_len=1; vec_data={10,11,12,13} accepted in cycle t.
   - Required: sys_start[0..3] high exactly at t+1..t+4 with data 10..13; done=1 only at t+5; sys_data_in zero elsewhere.
2. Four vectors back-to-back, N=4:
   - Stimulus: cmd_len=4; vectors v0..v3 with v_k[r]=16k+r, no gaps.
   - Required: row r shows 16k+r at cycle t0+1+r+k; done one cycle after row 3 shows 51.
3. Bubble handling:
   - Stimulus: cmd_len=3; vec_valid dropped for 2 cycles between the 1st and 2nd vectors.
   - Required: every row shows the same 2-cycle sys_start gap, shifted by r; no data lost or duplicated; vec_ready stays 1 during the gap.
4. Zero-length command:
   - Stimulus: cmd_len=0.
   - Required: done pulses the next cycle; no sys_start asserted; vec_ready never asserted; busy stays 0.
5. Mid-stream reset:
   - Stimulus: rst driven low asynchronously between edges after 2 of 5 vectors.
   - Required: all sys_start and sys_data_in read 0 before the next edge; no done pulse; after release, a fresh cmd_len=1 behaves as in test 1.
6. Back-to-back commands:
   - Stimulus: second command (cmd_len=2) presented with cmd_valid held high.
   - Required: it is accepted in the first command's done cycle; its row-0 output does not start before the first command's row-3 output has finished; two separate done pulses.
